// File: rtl/lt24_pkg.sv
// lt24_pkg: shared states, types and constants for the LT24 layer streamer
package lt24_pkg;
    typedef enum logic [2:0] {IDLE, CMD, FETCH, WAIT, STROBE, DONE} state_e;
    typedef logic [15:0] rgb565_t;
    localparam rgb565_t LT24_CMD_MEMWR = 16'h002C;
    localparam rgb565_t KEY_COLOR_DEF = 16'hF81F;
    localparam int H_RES_DEF = 240;
    localparam int V_RES_DEF = 320;
endpackage

// File: rtl/lt24_wr_strobe.sv
// lt24_wr_strobe: one WR_N write cycle (WR_LO low, WR_HI high) per start pulse
module lt24_wr_strobe #(
    parameter int WR_LO = 2,
    parameter int WR_HI = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic wr_n_o,
    output logic done_o
);
    localparam int CW = $clog2(WR_LO + WR_HI + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic act_q, act_d, wr_n_q, wr_n_d;
    assign done_o = act_q && (cnt_q == CW'(WR_LO + WR_HI - 1));
    assign wr_n_o = wr_n_q;
    always_comb begin
        act_d  = start_i || (act_q && !done_o);
        cnt_d  = start_i ? '0 : (act_q && !done_o) ? cnt_q + CW'(1) : cnt_q;
        wr_n_d = !(act_d && cnt_d < CW'(WR_LO));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            cnt_q  <= '0;
            wr_n_q <= 1'b1;
        end else begin
            act_q  <= act_d;
            cnt_q  <= cnt_d;
            wr_n_q <= wr_n_d;
        end
    end
endmodule

// File: rtl/lt24_layer_streamer.sv
// lt24_layer_streamer: composites background + keyed sprite layers and streams a frame to the LT24 bus
module lt24_layer_streamer
    import lt24_pkg::*;
#(
    parameter int      H_RES     = H_RES_DEF,
    parameter int      V_RES     = V_RES_DEF,
    parameter int      BG_SHIFT  = 2,
    parameter int      BG_AW     = 13,
    parameter int      NSPR      = 2,
    parameter int      SPR_WL2   = 6,
    parameter int      SPR_HL2   = 6,
    parameter rgb565_t KEY_COLOR = KEY_COLOR_DEF,
    parameter int      WR_LO     = 2,
    parameter int      WR_HI     = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_req,
    output logic                              busy,
    output logic                              frame_done,
    input  logic [NSPR*9-1:0]                 spr_x,
    input  logic [NSPR*9-1:0]                 spr_y,
    input  logic [NSPR-1:0]                   spr_en,
    output logic [BG_AW-1:0]                  bg_addr,
    output logic                              bg_rd,
    input  logic [15:0]                       bg_rdata,
    output logic [NSPR*(SPR_WL2+SPR_HL2)-1:0] spr_addr,
    output logic [NSPR-1:0]                   spr_rd,
    input  logic [NSPR*16-1:0]                spr_rdata,
    output logic                              lcd_cs_n,
    output logic                              lcd_rs,
    output logic                              lcd_wr_n,
    output logic                              lcd_rd_n,
    output logic [15:0]                       lcd_d
);
    localparam int XW  = $clog2(H_RES);
    localparam int YW  = $clog2(V_RES);
    localparam int SAW = SPR_WL2 + SPR_HL2;
    state_e state_q, state_d;
    logic req_q, pend_q, accept, rise, fetch, last_x, last;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [NSPR*9-1:0] sx_q, sy_q;
    logic [NSPR-1:0] en_q, hit, hit_q;
    logic rs_q, rs_d, done_q, wr_start, wr_done;
    rgb565_t d_q, d_d, pix;
    assign rise     = frame_req && !req_q;
    assign accept   = (state_q == IDLE) && pend_q;
    assign fetch    = (state_q == FETCH);
    assign last_x   = (x_q == XW'(H_RES - 1));
    assign last     = last_x && (y_q == YW'(V_RES - 1));
    assign busy     = (state_q inside {CMD, FETCH, WAIT, STROBE}) || accept;
    assign lcd_cs_n = !(state_q inside {CMD, FETCH, WAIT, STROBE});
    assign lcd_rd_n = 1'b1;
    assign lcd_rs   = rs_q;
    assign lcd_d    = d_q;
    assign frame_done = done_q;
    assign bg_rd    = fetch;
    assign spr_rd   = {NSPR{fetch}};
    assign bg_addr  = fetch ? BG_AW'(y_q >> BG_SHIFT) * BG_AW'(H_RES >> BG_SHIFT) + BG_AW'(x_q >> BG_SHIFT) : '0;
    // 10-bit offsets so sprites hanging past the screen edge clip instead of wrapping
    for (genvar i = 0; i < NSPR; i++) begin : g_spr
        logic [9:0] dx, dy;
        assign dx = 10'(x_q) - 10'(sx_q[9*i +: 9]);
        assign dy = 10'(y_q) - 10'(sy_q[9*i +: 9]);
        assign hit[i] = en_q[i] && 10'(x_q) >= 10'(sx_q[9*i +: 9]) && dx < 10'(1 << SPR_WL2)
                      && 10'(y_q) >= 10'(sy_q[9*i +: 9]) && dy < 10'(1 << SPR_HL2);
        assign spr_addr[SAW*i +: SAW] = (fetch && hit[i]) ? {dy[SPR_HL2-1:0], dx[SPR_WL2-1:0]} : '0;
    end
    always_comb begin
        pix = bg_rdata;
        for (int i = 0; i < NSPR; i++)
            if (hit_q[i] && spr_rdata[16*i +: 16] != KEY_COLOR) pix = spr_rdata[16*i +: 16];
    end
    lt24_wr_strobe #(.WR_LO(WR_LO), .WR_HI(WR_HI)) u_wr (
        .clk(clk), .rst_n(rst_n), .start_i(wr_start), .wr_n_o(lcd_wr_n), .done_o(wr_done)
    );
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rs_d     = rs_q;
        d_d      = d_q;
        wr_start = 1'b0;
        case (state_q)
            IDLE: if (pend_q) begin
                state_d  = CMD;
                wr_start = 1'b1;
                rs_d     = 1'b0;
                d_d      = LT24_CMD_MEMWR;
                x_d      = '0;
                y_d      = '0;
            end
            CMD:   state_d = wr_done ? FETCH : CMD;
            FETCH: state_d = WAIT;
            WAIT: begin
                state_d  = STROBE;
                wr_start = 1'b1;
                rs_d     = 1'b1;
                d_d      = pix;
            end
            STROBE: if (wr_done) begin
                state_d = last ? DONE : FETCH;
                x_d     = last_x ? '0 : x_q + XW'(1);
                y_d     = last ? '0 : last_x ? y_q + YW'(1) : y_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            en_q    <= '0;
            hit_q   <= '0;
            rs_q    <= 1'b1;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= frame_req;
            pend_q  <= rise || (pend_q && !accept);
            x_q     <= x_d;
            y_q     <= y_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            done_q  <= (state_q == DONE);
            if (accept) begin
                sx_q <= spr_x;
                sy_q <= spr_y;
                en_q <= spr_en;
            end
            if (fetch) hit_q <= hit;
        end
    end
endmodule
